jogo_sequencia_unidade_controle: RTL and testbench
==================================================

Name: jogo_sequencia_unidade_controle

Overview:
Control unit for the next-generation sequence-memory game. Round-based play: round k requires the player to repeat plays 0..k, and each round is followed by the next until the last round. The jogada timeout counter is internal and parametrised, so the datapath no longer provides fimT. Drives the datapath's play-address counter (E), round counter (L) and play register (R).

Parameters:
TIMEOUT_CYCLES, 3000, clock cycles allowed per play in espera_jogada (>=2)
NUM_VIDAS, 3, lives loaded at game start (used only with JOGO_VIDAS_EN, >=1)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; state <- inicial
iniciar  in  1  start/restart request (level sampled each cycle)
jogada  in  1  one-cycle pulse, player made a play
igual  in  1  registered play equals stored sequence entry
fimE  in  1  address counter equals current round limit
fimL  in  1  round counter at last round
zeraE  out  1  clear address counter
contaE  out  1  increment address counter
zeraL  out  1  clear round counter
contaL  out  1  increment round counter
zeraR  out  1  clear play register
registraR  out  1  load play register
timeout  out  1  game ended by timeout
acertou  out  1  game won
errou  out  1  game lost by wrong play
pronto  out  1  any terminal state
db_estado  out  4  state code (F for illegal)
db_vidas  out  $clog2(NUM_VIDAS+1)  lives remaining (0 when macro off)

Behaviour:
- Moore outputs, decoded from current state only; the internal timer is registered.
- States/codes/outputs:
  - inicial 0: zeraE, zeraL, zeraR.
  - preparacao 1: zeraE, zeraL, zeraR; timer cleared.
  - nova_rodada 2: zeraE; timer cleared.
  - espera_jogada 3: timer increments.
  - registra 4: registraR.
  - comparacao 5: no asserted outputs.
  - proximo 6: contaE; timer cleared.
  - perde_vida 7: zeraE; timer cleared.
  - fim_rodada 8: contaL.
  - fim_acertou A: acertou, pronto.
  - fim_timeout C: timeout, pronto.
  - fim_errou E: errou, pronto.
- Transitions:
  - inicial -> preparacao if iniciar.
  - preparacao -> nova_rodada.
  - nova_rodada -> espera_jogada.
  - espera_jogada -> registra if jogada; else fim_timeout if timer == TIMEOUT_CYCLES-1; else stay.
  - jogada in the same cycle as the timeout value: jogada wins.
  - registra -> comparacao.
  - comparacao, in priority order:
    - ~igual -> fim_errou (or perde_vida, see Optional Feature).
    - fimE & fimL -> fim_acertou.
    - fimE -> fim_rodada.
    - otherwise -> proximo.
  - proximo -> espera_jogada.
  - fim_rodada -> nova_rodada.
  - fim_* -> preparacao if iniciar, else hold.
  - Illegal code -> inicial next cycle; db_estado = F meanwhile.
- Timer: width $clog2(TIMEOUT_CYCLES), reset 0. Clears in every state except espera_jogada, so each play gets exactly TIMEOUT_CYCLES cycles. Never wraps.
- Reset values: state inicial; zeraE = zeraL = zeraR = 1; all other outputs 0; db_estado 0; timer 0; db_vidas 0.
- Reset mid-game has priority over every input; the next cycle is inicial regardless of jogada/iniciar.
- Latency:
  - jogada to registraR: 1 cycle.
  - jogada to terminal or proximo state: 3 cycles.
  - iniciar in a terminal state to preparacao: 1 cycle (restart without reset).

Optional Feature:
- Macro JOGO_VIDAS_EN.
- Defined:
  - Lives counter is loaded with NUM_VIDAS in preparacao and drives db_vidas.
  - In comparacao, ~igual with vidas > 1 -> perde_vida: decrement lives, then -> nova_rodada, replaying the same round from address 0 (round counter untouched).
  - ~igual with vidas == 1 -> fim_errou, with db_vidas then 0.
  - Timeout still ends the game immediately.
- Undefined: no lives register; db_vidas tied 0; ~igual -> fim_errou; perde_vida unreachable (treated as legal, exits to nova_rodada).

Test Plan:
- Setup: TIMEOUT_CYCLES=8, fimL asserted in round 2. Perfect game: iniciar, 1+2+3 correct plays with fimE at round ends -> fim_rodada seen twice, then fim_acertou; acertou=1, pronto=1, db_estado=A.
- Wrong play in round 1, macro off: igual=0 at comparacao -> db_estado E, errou=1, contaL never pulsed after error.
- Timeout: no jogada for 8 cycles in espera_jogada -> 9th cycle db_estado C, timeout=1. jogada on the 8th cycle -> registra, no timeout.
- Macro on, NUM_VIDAS=3: three wrong plays in round 0 -> perde_vida twice (db_vidas 3->2->1), round replayed, third error -> fim_errou, db_vidas=0.
- Reset asserted in comparacao with igual=1, fimE=1 -> next cycle db_estado 0, zeraE=zeraL=zeraR=1, no contaL pulse.
- Restart: in fim_timeout pulse iniciar -> preparacao next cycle, timer 0, zeraL=1; a subsequent game completes normally.

Source files
------------

// File: rtl/jogo_sequencia_unidade_controle.sv
// Control unit for the sequence-memory game: round FSM plus play timeout.
// Optional lives counter is enabled by defining JOGO_VIDAS_EN.
module jogo_sequencia_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int NUM_VIDAS      = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             iniciar,
    input  logic                             jogada,
    input  logic                             igual,
    input  logic                             fimE,
    input  logic                             fimL,
    output logic                             zeraE,
    output logic                             contaE,
    output logic                             zeraL,
    output logic                             contaL,
    output logic                             zeraR,
    output logic                             registraR,
    output logic                             timeout,
    output logic                             acertou,
    output logic                             errou,
    output logic                             pronto,
    output logic [3:0]                       db_estado,
    output logic [$clog2(NUM_VIDAS+1)-1:0]   db_vidas
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        NOVA_RODADA   = 4'h2,
        ESPERA_JOGADA = 4'h3,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROXIMO       = 4'h6,
        PERDE_VIDA    = 4'h7,
        FIM_RODADA    = 4'h8,
        FIM_ACERTOU   = 4'hA,
        FIM_TIMEOUT   = 4'hC,
        FIM_ERROU     = 4'hE
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;

`ifdef JOGO_VIDAS_EN
    localparam int VW = $clog2(NUM_VIDAS + 1);
    logic [VW-1:0] vidas_q, vidas_d;
`endif

    // Next-state, timer and Moore output decode from the current state
    always_comb begin
        estado_d  = estado_q;
        timer_d   = '0;
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        timeout   = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        pronto    = 1'b0;
        db_estado = estado_q;
`ifdef JOGO_VIDAS_EN
        vidas_d   = vidas_q;
`endif
        case (estado_q)
            INICIAL: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                zeraE    = 1'b1;
                zeraL    = 1'b1;
                zeraR    = 1'b1;
                estado_d = NOVA_RODADA;
`ifdef JOGO_VIDAS_EN
                vidas_d  = VW'(NUM_VIDAS);
`endif
            end
            NOVA_RODADA: begin
                zeraE    = 1'b1;
                estado_d = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                // Saturate rather than wrap; the state leaves at T_MAX anyway
                if (timer_q != T_MAX) timer_d = timer_q + TW'(1);
                else                  timer_d = timer_q;
                if (jogada)                estado_d = REGISTRA;
                else if (timer_q == T_MAX) estado_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                registraR = 1'b1;
                estado_d  = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual) begin
`ifdef JOGO_VIDAS_EN
                    if (vidas_q > VW'(1)) begin
                        estado_d = PERDE_VIDA;
                    end else begin
                        estado_d = FIM_ERROU;
                        vidas_d  = '0;
                    end
`else
                    estado_d = FIM_ERROU;
`endif
                end else if (fimE && fimL) begin
                    estado_d = FIM_ACERTOU;
                end else if (fimE) begin
                    estado_d = FIM_RODADA;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                contaE   = 1'b1;
                estado_d = ESPERA_JOGADA;
            end
            PERDE_VIDA: begin
                // Replay the same round: address cleared, round untouched
                zeraE    = 1'b1;
                estado_d = NOVA_RODADA;
`ifdef JOGO_VIDAS_EN
                vidas_d  = vidas_q - VW'(1);
`endif
            end
            FIM_RODADA: begin
                contaL   = 1'b1;
                estado_d = NOVA_RODADA;
            end
            FIM_ACERTOU: begin
                acertou = 1'b1;
                pronto  = 1'b1;
                if (iniciar) estado_d = PREPARACAO;
            end
            FIM_TIMEOUT: begin
                timeout = 1'b1;
                pronto  = 1'b1;
                if (iniciar) estado_d = PREPARACAO;
            end
            FIM_ERROU: begin
                errou  = 1'b1;
                pronto = 1'b1;
                if (iniciar) estado_d = PREPARACAO;
            end
            default: begin
                estado_d  = INICIAL;
                db_estado = 4'hF;
            end
        endcase
    end

    // State, timer and lives registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            timer_q  <= '0;
`ifdef JOGO_VIDAS_EN
            vidas_q  <= '0;
`endif
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
`ifdef JOGO_VIDAS_EN
            vidas_q  <= vidas_d;
`endif
        end
    end

`ifdef JOGO_VIDAS_EN
    assign db_vidas = vidas_q;
`else
    assign db_vidas = '0;
`endif

endmodule

// File: tb/tb_jogo_sequencia_unidade_controle.sv
// Directed bench for the game control unit with a state/output scoreboard.
// Builds with or without JOGO_VIDAS_EN.
module tb_jogo_sequencia_unidade_controle;

    localparam int TO = 8;
    localparam int NV = 3;
    localparam int VW = $clog2(NV + 1);

    logic clock = 1'b0;
    logic reset, iniciar, jogada, igual, fimE, fimL;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic timeout, acertou, errou, pronto;
    logic [3:0] db_estado;
    logic [VW-1:0] db_vidas;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] est;
        logic [9:0] outs;
    } exp_t;

    exp_t sb[$];

    jogo_sequencia_unidade_controle #(
        .TIMEOUT_CYCLES(TO),
        .NUM_VIDAS(NV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .jogada(jogada),
        .igual(igual),
        .fimE(fimE),
        .fimL(fimL),
        .zeraE(zeraE),
        .contaE(contaE),
        .zeraL(zeraL),
        .contaL(contaL),
        .zeraR(zeraR),
        .registraR(registraR),
        .timeout(timeout),
        .acertou(acertou),
        .errou(errou),
        .pronto(pronto),
        .db_estado(db_estado),
        .db_vidas(db_vidas)
    );

    always #5 clock = ~clock;

    // {zeraE,contaE,zeraL,contaL,zeraR,registraR,timeout,acertou,errou,pronto}
    function automatic logic [9:0] exp_outs(input logic [3:0] est);
        case (est)
            4'h0, 4'h1: return 10'b1010100000;
            4'h2, 4'h7: return 10'b1000000000;
            4'h4:       return 10'b0000010000;
            4'h6:       return 10'b0100000000;
            4'h8:       return 10'b0001000000;
            4'hA:       return 10'b0000000101;
            4'hC:       return 10'b0000001001;
            4'hE:       return 10'b0000000011;
            default:    return 10'b0000000000;
        endcase
    endfunction

    function automatic logic [9:0] obs_outs();
        return {zeraE, contaE, zeraL, contaL, zeraR,
                registraR, timeout, acertou, errou, pronto};
    endfunction

    task automatic cyc(input logic rst, input logic ini, input logic jog,
                       input logic ig, input logic fe, input logic fl,
                       input logic [3:0] est, input string tag);
        exp_t e;
        reset   = rst;
        iniciar = ini;
        jogada  = jog;
        igual   = ig;
        fimE    = fe;
        fimL    = fl;
        e.est   = est;
        e.outs  = exp_outs(est);
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        tests++;
        assert (db_estado === e.est) else begin
            fails++;
            $error("FAIL %s db_estado got %h expected %h",
                   tag, db_estado, e.est);
        end
        tests++;
        assert (obs_outs() === e.outs) else begin
            fails++;
            $error("FAIL %s outputs got %b expected %b",
                   tag, obs_outs(), e.outs);
        end
    endtask

    task automatic idle(input logic [3:0] est, input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, est, tag);
    endtask

    task automatic start(input string tag);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, tag);
    endtask

    task automatic play(input logic ig, input logic fe, input logic fl,
                        input logic [3:0] est, input string tag);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, tag);
        idle(4'h5, tag);
        cyc(1'b0, 1'b0, 1'b0, ig, fe, fl, est, tag);
    endtask

    task automatic chk_vidas(input logic [VW-1:0] ev, input string tag);
        tests++;
        assert (db_vidas === ev) else begin
            fails++;
            $error("FAIL %s db_vidas got %0d expected %0d",
                   tag, db_vidas, ev);
        end
    endtask

    task automatic perfect_game(input string tag);
        idle(4'h2, tag);
        idle(4'h3, tag);
        play(1'b1, 1'b1, 1'b0, 4'h8, {tag, "_r0p0"});
        idle(4'h2, tag);
        idle(4'h3, tag);
        play(1'b1, 1'b0, 1'b0, 4'h6, {tag, "_r1p0"});
        idle(4'h3, tag);
        play(1'b1, 1'b1, 1'b0, 4'h8, {tag, "_r1p1"});
        idle(4'h2, tag);
        idle(4'h3, tag);
        play(1'b1, 1'b0, 1'b1, 4'h6, {tag, "_r2p0"});
        idle(4'h3, tag);
        play(1'b1, 1'b0, 1'b1, 4'h6, {tag, "_r2p1"});
        idle(4'h3, tag);
        play(1'b1, 1'b1, 1'b1, 4'hA, {tag, "_r2p2"});
        idle(4'hA, {tag, "_hold"});
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        jogada  = 1'b0;
        igual   = 1'b0;
        fimE    = 1'b0;
        fimL    = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "reset");
        chk_vidas('0, "reset_vidas");
        idle(4'h0, "idle");
        start("start");
        perfect_game("win");
        start("restart_win");

`ifdef JOGO_VIDAS_EN
        idle(4'h2, "lv_nr");
        chk_vidas(VW'(3), "lv_load");
        idle(4'h3, "lv_esp");
        play(1'b0, 1'b0, 1'b0, 4'h7, "lv_err1");
        idle(4'h2, "lv_replay1");
        chk_vidas(VW'(2), "lv_dec1");
        idle(4'h3, "lv_esp");
        play(1'b0, 1'b0, 1'b0, 4'h7, "lv_err2");
        idle(4'h2, "lv_replay2");
        chk_vidas(VW'(1), "lv_dec2");
        idle(4'h3, "lv_esp");
        play(1'b0, 1'b0, 1'b0, 4'hE, "lv_err3");
        chk_vidas('0, "lv_zero");
`else
        idle(4'h2, "wr_nr");
        idle(4'h3, "wr_esp");
        play(1'b1, 1'b1, 1'b0, 4'h8, "wr_r0");
        idle(4'h2, "wr_nr1");
        idle(4'h3, "wr_esp1");
        play(1'b0, 1'b0, 1'b0, 4'hE, "wrong");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hE, "wrong_hold");
        idle(4'hE, "wrong_hold2");
        chk_vidas('0, "wr_vidas");
`endif

        start("restart_err");
        idle(4'h2, "to_nr");
        idle(4'h3, "to_esp0");
        repeat (TO - 1) idle(4'h3, "to_wait");
        idle(4'hC, "timeout");
        idle(4'hC, "timeout_hold");

        start("restart_to");
        idle(4'h2, "lim_nr");
        idle(4'h3, "lim_esp0");
        repeat (TO - 1) idle(4'h3, "lim_wait");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, "jog_at_limit");
        idle(4'h5, "lim_cmp");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8, "lim_fimrod");

        idle(4'h2, "rc_nr");
        idle(4'h3, "rc_esp");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, "rc_reg");
        idle(4'h5, "rc_cmp");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, "reset_cmp");
        idle(4'h0, "after_reset");

        start("to2_start");
        idle(4'h2, "to2_nr");
        idle(4'h3, "to2_esp0");
        repeat (TO - 1) idle(4'h3, "to2_wait");
        idle(4'hC, "to2_timeout");
        start("restart_from_to");
        perfect_game("win2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
